// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a blocking refill FSM,
// full flush, and saturating hit/miss statistics counters.
module inst_cache #(
  parameter int N_ADDR  = 32,
  parameter int N_DATA  = 32,
  parameter int N_LINES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_ren,
  input  logic [N_ADDR-1:0] i_inst_addr,
  output logic [N_DATA-1:0] o_inst_data,
  output logic              o_stall_req,
  input  logic              i_flush,
  output logic              o_mem_req,
  output logic [N_ADDR-1:0] o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [N_DATA-1:0] i_mem_rdata,
  output logic [15:0]       o_hit_cnt,
  output logic [15:0]       o_miss_cnt
);

  localparam int IDX_W = $clog2(N_LINES);
  localparam int TAG_W = N_ADDR - IDX_W - 2;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag_mem  [N_LINES];
  logic [N_DATA-1:0]   r_data_mem [N_LINES];
  logic [N_ADDR-1:0]   r_fill_addr;
  logic                r_mem_req;
  logic                r_drop;
  logic                r_fill_done;
  logic [15:0]         r_hit_cnt;
  logic [15:0]         r_miss_cnt;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_fill_idx;
  logic [TAG_W-1:0]    w_fill_tag;
  logic                w_hit;
  logic                w_start;
  logic                w_fill_ack;
  logic [1:0]          w_unused_addr_lsb;

  assign w_idx             = i_inst_addr[IDX_W+1:2];
  assign w_tag             = i_inst_addr[N_ADDR-1:IDX_W+2];
  assign w_fill_idx        = r_fill_addr[IDX_W+1:2];
  assign w_fill_tag        = r_fill_addr[N_ADDR-1:IDX_W+2];
  assign w_unused_addr_lsb = i_inst_addr[1:0];

  // Lookup is only trusted in IDLE; during a refill every fetch stalls.
  assign w_hit       = i_inst_ren & r_valid[w_idx] & (r_tag_mem[w_idx] == w_tag) & (r_state == S_IDLE);
  assign o_inst_data = w_hit ? r_data_mem[w_idx] : {N_DATA{1'b0}};
  assign o_stall_req = i_inst_ren & ~w_hit;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_fill_addr;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_miss_cnt  = r_miss_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fill_ack  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_inst_ren & ~w_hit & ~i_flush) begin
          w_state_nxt = S_REFILL;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REFILL: begin
        if (i_mem_rvalid) begin
          w_state_nxt = S_IDLE;
          w_fill_ack  = 1'b1;
        end else begin
          w_state_nxt = S_REFILL;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_valid     <= {N_LINES{1'b0}};
      r_fill_addr <= {N_ADDR{1'b0}};
      r_mem_req   <= 1'b0;
      r_drop      <= 1'b0;
      r_fill_done <= 1'b0;
      r_hit_cnt   <= 16'd0;
      r_miss_cnt  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_fill_addr <= {i_inst_addr[N_ADDR-1:2], 2'b00};
        r_mem_req   <= 1'b1;
        r_drop      <= 1'b0;
      end else if (w_fill_ack) begin
        r_mem_req <= 1'b0;
        r_drop    <= 1'b0;
      end else if (i_flush && (r_state == S_REFILL)) begin
        r_drop <= 1'b1;
      end
      // Flush wins over the valid-set of a completing fill.
      if (i_flush) begin
        r_valid <= {N_LINES{1'b0}};
      end else if (w_fill_ack && !r_drop) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      // The first hit after a fill is the access already counted as a miss.
      if (w_fill_ack) begin
        r_fill_done <= 1'b1;
      end else if (i_inst_ren) begin
        r_fill_done <= 1'b0;
      end
      if (w_hit && !r_fill_done && (r_hit_cnt != 16'hFFFF)) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_start && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fill_ack && !i_rst) begin
      r_tag_mem[w_fill_idx]  <= w_fill_tag;
      r_data_mem[w_fill_idx] <= i_mem_rdata;
    end
  end

endmodule
